// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, GF(2^8) constant multipliers and MixColumns FSM encoding
package aes_pkg;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [31:0]  aes_col_t;
    typedef logic [127:0] aes_state_t;

    localparam int AES_NCOLS = 4;

    typedef enum logic [1:0] {MC_IDLE, MC_BUSY, MC_DONE} mc_state_e;

    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by one of the MixColumns/InvMixColumns coefficients; anything else is treated as 01
    function automatic aes_byte_t gf_mul_const(input aes_byte_t b, input aes_byte_t c);
        aes_byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c == 8'h02) ? x2 :
               (c == 8'h03) ? x2 ^ b :
               (c == 8'h09) ? x8 ^ b :
               (c == 8'h0b) ? x8 ^ x2 ^ b :
               (c == 8'h0d) ? x8 ^ x4 ^ b :
               (c == 8'h0e) ? x8 ^ x4 ^ x2 : b;
    endfunction

endpackage

// File: rtl/aes_mix_column_unit.sv
// aes_mix_column_unit: combinational single-column MixColumns (inv=0) / InvMixColumns (inv=1)
module aes_mix_column_unit
    import aes_pkg::*;
(
    input  aes_col_t col,
    input  logic     inv,
    output aes_col_t result
);

    // First row of the circulant matrix; row r uses it rotated right by r
    function automatic aes_byte_t coef(input logic inv_sel, input logic [1:0] idx);
        return inv_sel ? ((idx == 2'd0) ? 8'h0e : (idx == 2'd1) ? 8'h0b : (idx == 2'd2) ? 8'h0d : 8'h09)
                       : ((idx == 2'd0) ? 8'h02 : (idx == 2'd1) ? 8'h03 : 8'h01);
    endfunction

    // Row r = XOR over k of coef[(k-r) mod 4] * col[k], row 0 being the MSByte
    always_comb begin
        result = '0;
        for (int r = 0; r < AES_NCOLS; r++)
            for (int k = 0; k < AES_NCOLS; k++)
                result[31-8*r -: 8] = result[31-8*r -: 8] ^ gf_mul_const(col[31-8*k -: 8], coef(inv, 2'(k - r)));
    end

endmodule

// File: rtl/aes_mix_columns_engine.sv
// aes_mix_columns_engine: sequential (Inv)MixColumns engine, COLS_PER_CYCLE columns per beat;
// define AES_MC_BYPASS_EN to add an in_bypass port that passes blocks through untouched
module aes_mix_columns_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  aes_state_t in_state,
    input  logic       in_inv,
`ifdef AES_MC_BYPASS_EN
    input  logic       in_bypass,
`endif
    output logic       out_valid,
    input  logic       out_ready,
    output aes_state_t out_state,
    output logic       busy
);

    localparam int N = AES_NCOLS / COLS_PER_CYCLE;

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mc_state_e  state;
    logic [2:0] col_cnt;
    logic [1:0] beat;
    aes_state_t work, next_work;
    logic       inv_q, bypass_q, bypass_in;
    aes_col_t   col_in  [COLS_PER_CYCLE];
    aes_col_t   col_mix [COLS_PER_CYCLE];

`ifdef AES_MC_BYPASS_EN
    assign bypass_in = in_bypass;
`else
    assign bypass_in = 1'b0;
`endif

    // col_cnt runs 0..N; the extra count is the cycle that publishes the result, masked here to stay in range
    assign beat = col_cnt[1:0] & 2'(N - 1);

    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
        assign col_in[i] = work[127 - 32*(int'(beat)*COLS_PER_CYCLE + i) -: 32];
        aes_mix_column_unit u_unit (
            .col    (col_in[i]),
            .inv    (inv_q),
            .result (col_mix[i])
        );
    end

    // Splice the transformed (or bypassed) columns of the current beat into the working state
    always_comb begin
        next_work = work;
        for (int c = 0; c < AES_NCOLS; c++)
            if (c / COLS_PER_CYCLE == int'(beat))
                next_work[127-32*c -: 32] = bypass_q ? col_in[c % COLS_PER_CYCLE] : col_mix[c % COLS_PER_CYCLE];
    end

    // Handshake FSM with registered outputs; the cycle after the last beat loads out_state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MC_IDLE;
            col_cnt   <= '0;
            work      <= '0;
            inv_q     <= 1'b0;
            bypass_q  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_state <= '0;
        end else begin
            case (state)
                MC_IDLE: if (in_valid) begin
                    work     <= in_state;
                    inv_q    <= in_inv;
                    bypass_q <= bypass_in;
                    col_cnt  <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    state    <= MC_BUSY;
                end
                MC_BUSY: if (col_cnt == 3'(N)) begin
                    out_state <= work;
                    out_valid <= 1'b1;
                    state     <= MC_DONE;
                end else begin
                    work    <= next_work;
                    col_cnt <= col_cnt + 3'd1;
                end
                MC_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= MC_IDLE;
                end
                default: state <= MC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_mix_columns_engine.sv
// tb_aes_mix_columns_engine: scoreboard bench driving a 4-column and a 1-column engine side by side
module tb_aes_mix_columns_engine;

    localparam logic [127:0] S1   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] F1   = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] S3   = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] F3   = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] ONES = 128'h01010101_01010101_01010101_01010101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst4, rst1, iv4, iv1, in_inv, in_bypass, out_ready;
    logic [127:0] in_state;
    logic         rdy4, ov4, busy4, rdy1, ov1, busy1;
    logic [127:0] os4, os1;

    aes_mix_columns_engine #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst4), .in_valid(iv4), .in_ready(rdy4), .in_state(in_state), .in_inv(in_inv),
`ifdef AES_MC_BYPASS_EN
        .in_bypass(in_bypass),
`endif
        .out_valid(ov4), .out_ready(out_ready), .out_state(os4), .busy(busy4));

    aes_mix_columns_engine #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst1), .in_valid(iv1), .in_ready(rdy1), .in_state(in_state), .in_inv(in_inv),
`ifdef AES_MC_BYPASS_EN
        .in_bypass(in_bypass),
`endif
        .out_valid(ov1), .out_ready(out_ready), .out_state(os1), .busy(busy1));

    int           compared = 0, mismatched = 0, cyc = 0;
    logic [127:0] exp4[$], exp1[$];
    int           acc4[$], acc1[$];
    logic         ov4_prev = 1'b0, ov1_prev = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s", name);
    endtask

    // Monitor for the 4-column engine: acceptance times, latency and output data
    always @(negedge clk) begin
        logic [127:0] e;
        int a;
        if (rst4 && iv4 && rdy4) acc4.push_back(cyc + 1);
        if (rst4 && ov4 && !ov4_prev) begin
            if (acc4.size() == 0) fail("lat4 no accept");
            else begin
                a = acc4.pop_front();
                check("lat4", 128'(cyc - a), 128'd2);
            end
        end
        ov4_prev = ov4;
        if (rst4 && ov4 && out_ready) begin
            if (exp4.size() == 0) fail("data4 unexpected output");
            else begin
                e = exp4.pop_front();
                check("data4", os4, e);
            end
        end
    end

    // Monitor for the 1-column engine
    always @(negedge clk) begin
        logic [127:0] e;
        int a;
        if (rst1 && iv1 && rdy1) acc1.push_back(cyc + 1);
        if (rst1 && ov1 && !ov1_prev) begin
            if (acc1.size() == 0) fail("lat1 no accept");
            else begin
                a = acc1.pop_front();
                check("lat1", 128'(cyc - a), 128'd5);
            end
        end
        ov1_prev = ov1;
        if (rst1 && ov1 && out_ready) begin
            if (exp1.size() == 0) fail("data1 unexpected output");
            else begin
                e = exp1.pop_front();
                check("data1", os1, e);
            end
        end
    end

    // Offer a block to the selected engines and return once each has accepted it
    task automatic send(input logic [127:0] s, input logic inv, input logic byp, input logic [127:0] e,
                        input bit to4, input bit to1, input bit expect_out);
        logic a4, a1;
        in_state  = s;
        in_inv    = inv;
        in_bypass = byp;
        iv4       = to4;
        iv1       = to1;
        if (expect_out && to4) exp4.push_back(e);
        if (expect_out && to1) exp1.push_back(e);
        for (int i = 0; i < 100 && (iv4 || iv1); i++) begin
            @(negedge clk);
            a4 = iv4 && rdy4;
            a1 = iv1 && rdy1;
            @(posedge clk);
            #1;
            if (a4) iv4 = 1'b0;
            if (a1) iv1 = 1'b0;
        end
        if (iv4 || iv1) begin
            fail("send timeout");
            iv4 = 1'b0;
            iv1 = 1'b0;
        end
        in_inv    = ~inv;
        in_bypass = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && (exp4.size() != 0 || exp1.size() != 0); i++) @(negedge clk);
        if (exp4.size() != 0 || exp1.size() != 0) begin
            fail("drain timeout");
            exp4.delete();
            exp1.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst4 = 1'b0; rst1 = 1'b0; iv4 = 1'b0; iv1 = 1'b0;
        in_state = '0; in_inv = 1'b0; in_bypass = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst4 = 1'b1; rst1 = 1'b1;
        @(negedge clk);
        check("reset rdy4", 128'(rdy4), 128'd1);
        check("reset ov4", 128'(ov4), 128'd0);
        check("reset busy4", 128'(busy4), 128'd0);
        check("reset os4", os4, 128'd0);
        check("reset rdy1", 128'(rdy1), 128'd1);
        check("reset ov1", 128'(ov1), 128'd0);
        check("reset busy1", 128'(busy1), 128'd0);
        check("reset os1", os1, 128'd0);
        @(posedge clk);
        #1;

        send(S1, 1'b0, 1'b0, F1, 1, 1, 1);
        send(F1, 1'b1, 1'b0, S1, 1, 1, 1);
        send(S3, 1'b0, 1'b0, F3, 1, 1, 1);
        send(F3, 1'b1, 1'b0, S3, 1, 1, 1);
        send(ONES, 1'b0, 1'b0, ONES, 1, 1, 1);
        send(ONES, 1'b1, 1'b0, ONES, 1, 1, 1);
        send('0, 1'b1, 1'b0, '0, 1, 1, 1);
        wait_drain();

        // Back-pressure: hold the result, then release with a block already waiting
        out_ready = 1'b0;
        send(S1, 1'b0, 1'b0, F1, 1, 1, 1);
        for (int i = 0; i < 50 && !(ov4 && ov1); i++) @(negedge clk);
        if (!(ov4 && ov1)) fail("backpressure out_valid timeout");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold ov4", 128'(ov4), 128'd1);
            check("hold os4", os4, F1);
            check("hold rdy4", 128'(rdy4), 128'd0);
            check("hold ov1", 128'(ov1), 128'd1);
            check("hold os1", os1, F1);
            check("hold rdy1", 128'(rdy1), 128'd0);
        end
        @(posedge clk);
        #1;
        in_state = S3; in_inv = 1'b0; iv4 = 1'b1; iv1 = 1'b1;
        exp4.push_back(F3); exp1.push_back(F3);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release rdy4", 128'(rdy4), 128'd1);
        check("release rdy1", 128'(rdy1), 128'd1);
        @(posedge clk);
        #1;
        check("queued accept busy4", 128'(busy4), 128'd1);
        check("queued accept busy1", 128'(busy1), 128'd1);
        iv4 = 1'b0; iv1 = 1'b0; in_inv = 1'b1;
        wait_drain();

        // Asynchronous reset on beat 1 of a 1-column block discards it
        send(S1, 1'b0, 1'b0, F1, 0, 1, 0);
        @(posedge clk);
        #1;
        rst1 = 1'b0;
        #1;
        check("midreset rdy1", 128'(rdy1), 128'd1);
        check("midreset ov1", 128'(ov1), 128'd0);
        check("midreset busy1", 128'(busy1), 128'd0);
        check("midreset os1", os1, 128'd0);
        acc1.delete();
        @(posedge clk);
        #1;
        rst1 = 1'b1;
        send(S3, 1'b0, 1'b0, F3, 0, 1, 1);
        wait_drain();

`ifdef AES_MC_BYPASS_EN
        send(S1, 1'b0, 1'b1, S1, 1, 1, 1);
        send(S3, 1'b1, 1'b1, S3, 1, 1, 1);
        wait_drain();
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
